corefifo_fwft_pf: RTL and testbench

Parametrised first-word-fall-through read stage that sits between a COREFIFO controller/RAM and the read-side consumer. It prefetches up to PF_DEPTH words from a RAM with 1 or 2 cycles of read latency. It presents the head word on dout with empty low, so the consumer pops with rd_en and never waits on RAM latency. It generalises the fixed three-register FWFT stage: configurable depth and RAM latency, occupancy count, programmable almost-empty threshold, and a flush.

---
 rtl/corefifo_fwft_pf_if.sv | 29 ++
 rtl/corefifo_fwft_pf.sv | 104 ++++++++++
 tb/tb_corefifo_fwft_pf.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/corefifo_fwft_pf_if.sv
// Read-side bundle for corefifo_fwft_pf: upstream controller/RAM signals plus consumer signals.
// master = surrounding logic (upstream + consumer), slave = the FWFT prefetch stage.
interface corefifo_fwft_pf_if #(
   parameter int RWIDTH   = 18,
   parameter int PF_DEPTH = 4
);
   localparam int CW = $clog2(PF_DEPTH + 1);

   logic              flush;
   logic              fifo_empty;
   logic              fifo_rd_en;
   logic [RWIDTH-1:0] fifo_dout;
   logic              rd_en;
   logic [RWIDTH-1:0] dout;
   logic              empty;
   logic              aempty;
   logic [CW-1:0]     count;
   logic              underflow;

   modport master (
      output flush, fifo_empty, fifo_dout, rd_en,
      input  fifo_rd_en, dout, empty, aempty, count, underflow
   );

   modport slave (
      input  flush, fifo_empty, fifo_dout, rd_en,
      output fifo_rd_en, dout, empty, aempty, count, underflow
   );
endinterface

// File: rtl/corefifo_fwft_pf.sv
// First-word-fall-through prefetch stage between a COREFIFO controller/RAM and its consumer.
// Optional sticky underflow flag enabled by defining COREFIFO_FWFT_UNDERFLOW_EN.
module corefifo_fwft_pf #(
   parameter int RWIDTH     = 18,
   parameter int RAM_LAT    = 1,
   parameter int PF_DEPTH   = 4,
   parameter int AEMPTY_THR = 1
) (
   input  logic                clk,
   input  logic                rst,
   corefifo_fwft_pf_if.slave   bus
);
   localparam int CW = $clog2(PF_DEPTH + 1);
   localparam int PW = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;

   logic [RWIDTH-1:0]  mem [PF_DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [CW-1:0]      cnt;
   logic [RAM_LAT-1:0] vpipe;
   logic [31:0]        inflight;
   logic               empty_i;
   logic               pop;
   logic               req;
   logic               capture;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(PF_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < RAM_LAT; i++) begin
         inflight = inflight + 32'(vpipe[i]);
      end
   end

   assign empty_i = (cnt == '0);
   assign pop     = bus.rd_en && !empty_i;
   assign capture = vpipe[RAM_LAT-1];

   // Requests are held off while reset is asserted, exactly as during a flush.
   assign req = rst && !bus.fifo_empty && !bus.flush &&
                ((32'(cnt) + inflight - 32'(pop)) < 32'(PF_DEPTH));

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         vpipe  <= '0;
         // Storage is cleared so the head word reads zero out of reset.
         for (int unsigned i = 0; i < PF_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         vpipe  <= '0;
      end else begin
         vpipe[0] <= req;
         for (int unsigned i = 1; i < RAM_LAT; i++) begin
            vpipe[i] <= vpipe[i-1];
         end
         if (capture) begin
            mem[wr_ptr] <= bus.fifo_dout;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         if (capture && !pop) begin
            cnt <= cnt + CW'(1);
         end else if (pop && !capture) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

   assign bus.fifo_rd_en = req;
   assign bus.dout       = mem[rd_ptr];
   assign bus.empty      = empty_i;
   assign bus.count      = cnt;
   assign bus.aempty     = empty_i ||
                           (((32'(cnt) + inflight) <= 32'(AEMPTY_THR)) && bus.fifo_empty);

`ifdef COREFIFO_FWFT_UNDERFLOW_EN
   logic uflow;

   always_ff @(posedge clk) begin
      if (!rst) begin
         uflow <= 1'b0;
      end else if (bus.rd_en && empty_i) begin
         uflow <= 1'b1;
      end
   end

   assign bus.underflow = uflow;
`else
   assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_corefifo_fwft_pf.sv
// Directed bench for corefifo_fwft_pf: u1 uses RAM_LAT=1, u2 uses RAM_LAT=2, both PF_DEPTH=4.
// Upstream controller/RAM is a small array model with the matching read latency.
module tb_corefifo_fwft_pf;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   corefifo_fwft_pf_if #(.RWIDTH(18), .PF_DEPTH(4)) b1 ();
   corefifo_fwft_pf_if #(.RWIDTH(18), .PF_DEPTH(4)) b2 ();

   corefifo_fwft_pf #(.RWIDTH(18), .RAM_LAT(1), .PF_DEPTH(4), .AEMPTY_THR(1))
      u1 (.clk(clk), .rst(rst), .bus(b1));
   corefifo_fwft_pf #(.RWIDTH(18), .RAM_LAT(2), .PF_DEPTH(4), .AEMPTY_THR(1))
      u2 (.clk(clk), .rst(rst), .bus(b2));

   logic [17:0] um1 [256];
   logic [17:0] um2 [256];
   logic [7:0]  uw1 = '0, ur1 = '0, uw2 = '0, ur2 = '0;
   logic [17:0] a1, a2_0, a2_1;

   // Upstream owner flushes its own queue in the flush cycle; reset leaves it intact.
   always @(posedge clk) begin
      if (b1.flush) ur1 <= uw1;
      else if (b1.fifo_rd_en) begin
         a1  <= um1[ur1];
         ur1 <= ur1 + 8'd1;
      end
      if (b2.flush) ur2 <= uw2;
      else if (b2.fifo_rd_en) begin
         a2_0 <= um2[ur2];
         ur2  <= ur2 + 8'd1;
      end
      a2_1 <= a2_0;
   end

   assign b1.fifo_empty = (ur1 == uw1);
   assign b1.fifo_dout  = a1;
   assign b2.fifo_empty = (ur2 == uw2);
   assign b2.fifo_dout  = a2_1;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [17:0] d);
      um1[uw1] = d;
      uw1 = uw1 + 8'd1;
   endtask

   task automatic push2(input logic [17:0] d);
      um2[uw2] = d;
      uw2 = uw2 + 8'd1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      tick;
      tick;
      #1;
      checks++; if (b1.count !== 3'd0) begin errors++; $display("FAIL rst_count1 got %0d want 0", b1.count); end
      checks++; if (b1.empty !== 1'b1) begin errors++; $display("FAIL rst_empty1 got %b want 1", b1.empty); end
      checks++; if (b1.aempty !== 1'b1) begin errors++; $display("FAIL rst_aempty1 got %b want 1", b1.aempty); end
      checks++; if (b1.dout !== 18'h0) begin errors++; $display("FAIL rst_dout1 got %h want 0", b1.dout); end
      checks++; if (b1.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rden1 got %b want 0", b1.fifo_rd_en); end
      checks++; if (b1.underflow !== 1'b0) begin errors++; $display("FAIL rst_uflow1 got %b want 0", b1.underflow); end
      checks++; if (b2.count !== 3'd0) begin errors++; $display("FAIL rst_count2 got %0d want 0", b2.count); end
      checks++; if (b2.empty !== 1'b1) begin errors++; $display("FAIL rst_empty2 got %b want 1", b2.empty); end
      checks++; if (b2.dout !== 18'h0) begin errors++; $display("FAIL rst_dout2 got %h want 0", b2.dout); end
      rst = 1'b1;
   endtask

   task automatic test_fill;
      int n = 0;
      tick;
      push1(18'h11); push1(18'h12); push1(18'h13); push1(18'h14);
      #1;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) begin tick; #1; end
         if (b1.fifo_rd_en === 1'b1) n++;
         if (c == 1) begin
            checks++; if (b1.empty !== 1'b1) begin errors++; $display("FAIL fill_empty_c1 got %b want 1", b1.empty); end
         end
         if (c == 2) begin
            checks++; if (b1.empty !== 1'b0) begin errors++; $display("FAIL fill_empty_c2 got %b want 0", b1.empty); end
            checks++; if (b1.dout !== 18'h11) begin errors++; $display("FAIL fill_dout_c2 got %h want 11", b1.dout); end
         end
      end
      checks++; if (n != 4) begin errors++; $display("FAIL fill_req_pulses got %0d want 4", n); end
      checks++; if (b1.count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", b1.count); end
      checks++; if (b1.aempty !== 1'b0) begin errors++; $display("FAIL fill_aempty got %b want 0", b1.aempty); end
      push1(18'h15);
      #1;
      checks++; if (b1.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL full_no_req got %b want 0", b1.fifo_rd_en); end
      tick;
      b1.rd_en = 1'b1;
      #1;
      checks++; if (b1.fifo_rd_en !== 1'b1) begin errors++; $display("FAIL full_pop_req got %b want 1", b1.fifo_rd_en); end
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin tick; #1; end
         checks++; if (b1.empty !== 1'b0) begin errors++; $display("FAIL drain_empty k=%0d got %b want 0", k, b1.empty); end
         checks++; if (b1.dout !== 18'(18'h11 + k)) begin errors++; $display("FAIL drain_dout k=%0d got %h want %h", k, b1.dout, 18'(18'h11 + k)); end
      end
      tick;
      b1.rd_en = 1'b0;
      #1;
      checks++; if (b1.empty !== 1'b1) begin errors++; $display("FAIL drain_end_empty got %b want 1", b1.empty); end
      checks++; if (b1.count !== 3'd0) begin errors++; $display("FAIL drain_end_count got %0d want 0", b1.count); end
   endtask

   task automatic test_aempty;
      tick;
      push1(18'h21); push1(18'h22);
      repeat (4) tick;
      #1;
      checks++; if (b1.count !== 3'd2) begin errors++; $display("FAIL ae_count2 got %0d want 2", b1.count); end
      checks++; if (b1.aempty !== 1'b0) begin errors++; $display("FAIL ae_two_words got %b want 0", b1.aempty); end
      checks++; if (b1.dout !== 18'h21) begin errors++; $display("FAIL ae_dout21 got %h want 21", b1.dout); end
      b1.rd_en = 1'b1;
      tick;
      b1.rd_en = 1'b0;
      #1;
      checks++; if (b1.aempty !== 1'b1) begin errors++; $display("FAIL ae_one_word got %b want 1", b1.aempty); end
      checks++; if (b1.empty !== 1'b0) begin errors++; $display("FAIL ae_one_empty got %b want 0", b1.empty); end
      checks++; if (b1.dout !== 18'h22) begin errors++; $display("FAIL ae_dout22 got %h want 22", b1.dout); end
      push1(18'h23);
      #1;
      checks++; if (b1.aempty !== 1'b0) begin errors++; $display("FAIL ae_upstream_data got %b want 0", b1.aempty); end
      repeat (3) tick;
      #1;
      checks++; if (b1.count !== 3'd2) begin errors++; $display("FAIL ae_refill_count got %0d want 2", b1.count); end
      b1.rd_en = 1'b1;
      tick;
      #1;
      checks++; if (b1.dout !== 18'h23) begin errors++; $display("FAIL ae_dout23 got %h want 23", b1.dout); end
      tick;
      b1.rd_en = 1'b0;
      #1;
      checks++; if (b1.empty !== 1'b1) begin errors++; $display("FAIL ae_final_empty got %b want 1", b1.empty); end
      checks++; if (b1.aempty !== 1'b1) begin errors++; $display("FAIL ae_final_aempty got %b want 1", b1.aempty); end
   endtask

   task automatic test_underflow;
      logic exp_uf;
`ifdef COREFIFO_FWFT_UNDERFLOW_EN
      exp_uf = 1'b1;
`else
      exp_uf = 1'b0;
`endif
      tick;
      b1.rd_en = 1'b1;
      tick;
      b1.rd_en = 1'b0;
      #1;
      checks++; if (b1.underflow !== exp_uf) begin errors++; $display("FAIL uf_flag got %b want %b", b1.underflow, exp_uf); end
      checks++; if (b1.count !== 3'd0) begin errors++; $display("FAIL uf_count got %0d want 0", b1.count); end
      checks++; if (b1.empty !== 1'b1) begin errors++; $display("FAIL uf_empty got %b want 1", b1.empty); end
      push1(18'h31);
      tick;
      tick;
      #1;
      checks++; if (b1.dout !== 18'h31) begin errors++; $display("FAIL uf_ptr_dout got %h want 31", b1.dout); end
      checks++; if (b1.count !== 3'd1) begin errors++; $display("FAIL uf_ptr_count got %0d want 1", b1.count); end
      b1.rd_en = 1'b1;
      tick;
      b1.rd_en = 1'b0;
      b1.flush = 1'b1;
      tick;
      b1.flush = 1'b0;
      #1;
      checks++; if (b1.underflow !== exp_uf) begin errors++; $display("FAIL uf_after_flush got %b want %b", b1.underflow, exp_uf); end
   endtask

   task automatic test_back_to_back;
      tick;
      for (int i = 1; i <= 8; i++) push2(18'(i));
      b2.rd_en = 1'b1;
      #1;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) begin tick; #1; end
         if (c < 3) begin
            checks++; if (b2.empty !== 1'b1) begin errors++; $display("FAIL b2b_lat c=%0d empty got %b want 1", c, b2.empty); end
         end else if (c < 11) begin
            checks++; if (b2.empty !== 1'b0) begin errors++; $display("FAIL b2b_gap c=%0d empty got %b want 0", c, b2.empty); end
            checks++; if (b2.dout !== 18'(c - 2)) begin errors++; $display("FAIL b2b_dout c=%0d got %h want %h", c, b2.dout, 18'(c - 2)); end
         end else begin
            checks++; if (b2.empty !== 1'b1) begin errors++; $display("FAIL b2b_end_empty got %b want 1", b2.empty); end
            checks++; if (b2.count !== 3'd0) begin errors++; $display("FAIL b2b_end_count got %0d want 0", b2.count); end
         end
      end
      b2.rd_en = 1'b0;
   endtask

   task automatic test_flush;
      int w = 0;
      tick;
      push2(18'h41); push2(18'h42); push2(18'h43);
      #1;
      while (b2.count !== 3'd2 && w < 10) begin tick; #1; w++; end
      checks++; if (w != 4) begin errors++; $display("FAIL fl_fill_cycles got %0d want 4", w); end
      b2.flush = 1'b1;
      b2.rd_en = 1'b1;
      push2(18'h44);
      #1;
      checks++; if (b2.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL fl_req_during got %b want 0", b2.fifo_rd_en); end
      tick;
      b2.flush = 1'b0;
      b2.rd_en = 1'b0;
      #1;
      checks++; if (b2.count !== 3'd0) begin errors++; $display("FAIL fl_count got %0d want 0", b2.count); end
      checks++; if (b2.empty !== 1'b1) begin errors++; $display("FAIL fl_empty got %b want 1", b2.empty); end
      repeat (3) tick;
      #1;
      checks++; if (b2.count !== 3'd0) begin errors++; $display("FAIL fl_late_word got count %0d want 0", b2.count); end
      push2(18'hAA);
      #1;
      w = 0;
      while (b2.empty !== 1'b0 && w < 10) begin tick; #1; w++; end
      checks++; if (w != 3) begin errors++; $display("FAIL fl_aa_latency got %0d want 3", w); end
      checks++; if (b2.dout !== 18'hAA) begin errors++; $display("FAIL fl_aa_dout got %h want aa", b2.dout); end
      checks++; if (b2.count !== 3'd1) begin errors++; $display("FAIL fl_aa_count got %0d want 1", b2.count); end
      b2.rd_en = 1'b1;
      tick;
      b2.rd_en = 1'b0;
   endtask

   task automatic test_reset_mid;
      int w = 0;
      tick;
      push1(18'h51); push1(18'h52); push1(18'h53); push1(18'h54); push1(18'h55);
      #1;
      while (b1.count !== 3'd3 && w < 10) begin tick; #1; w++; end
      checks++; if (w != 4) begin errors++; $display("FAIL rm_fill_cycles got %0d want 4", w); end
      rst = 1'b0;
      tick;
      #1;
      checks++; if (b1.count !== 3'd0) begin errors++; $display("FAIL rm_count got %0d want 0", b1.count); end
      checks++; if (b1.empty !== 1'b1) begin errors++; $display("FAIL rm_empty got %b want 1", b1.empty); end
      checks++; if (b1.aempty !== 1'b1) begin errors++; $display("FAIL rm_aempty got %b want 1", b1.aempty); end
      checks++; if (b1.dout !== 18'h0) begin errors++; $display("FAIL rm_dout got %h want 0", b1.dout); end
      checks++; if (b1.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rm_req got %b want 0", b1.fifo_rd_en); end
      checks++; if (b1.underflow !== 1'b0) begin errors++; $display("FAIL rm_uflow got %b want 0", b1.underflow); end
      rst = 1'b1;
      #1;
      checks++; if (b1.fifo_rd_en !== 1'b1) begin errors++; $display("FAIL rm_resume_req got %b want 1", b1.fifo_rd_en); end
      tick;
      tick;
      #1;
      checks++; if (b1.dout !== 18'h55) begin errors++; $display("FAIL rm_next_dout got %h want 55", b1.dout); end
      checks++; if (b1.count !== 3'd1) begin errors++; $display("FAIL rm_next_count got %0d want 1", b1.count); end
      b1.rd_en = 1'b1;
      tick;
      b1.rd_en = 1'b0;
      #1;
      checks++; if (b1.empty !== 1'b1) begin errors++; $display("FAIL rm_final_empty got %b want 1", b1.empty); end
   endtask

   initial begin
      rst      = 1'b0;
      b1.flush = 1'b0;
      b1.rd_en = 1'b0;
      b2.flush = 1'b0;
      b2.rd_en = 1'b0;
      test_reset;
      test_fill;
      test_aempty;
      test_underflow;
      test_back_to_back;
      test_flush;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
